sram_dp_be: RTL and testbench

//   Parametrised simple dual-port SRAM: one write port, one read port, single clock.

---
 rtl/sram_pkg.sv | 29 ++
 rtl/sram_clr_ctrl.sv | 65 ++++++
 rtl/sram_dp_be.sv | 142 ++++++++++++++
 tb/tb_sram_dp_be.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the sram_dp_be scratchpad.
// clr_state_e is the state of the post-reset zero-fill sweep. be_merge
// overlays byte-enabled bytes of a new word onto an old one. It works at a
// fixed maximum width, so callers zero-extend their words going in and
// truncate the result coming out.
package sram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  localparam int MAX_DATA_W = 1024;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  function automatic logic [MAX_DATA_W-1:0] be_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_clr_ctrl.sv
// Zero-fill sequencer for sram_dp_be.
// After reset it walks o_clr_addr from 0 to DEPTH-1 and requests one
// all-bytes zero write per cycle. It then parks in READY until the next
// reset. o_init_done is a flop output that follows the READY state one cycle
// later. Any reset, including one in the middle of a sweep, restarts the
// sweep at address 0.
module sram_clr_ctrl
  import sram_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int CLR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        r_state;
  clr_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] w_clr_addr_nxt;
  logic              r_init_done;

  // State, sweep address and init_done registers. Reset is synchronous.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments. Every flop then
    // samples values from before the edge, whatever order the statements are in.
    if (rst) begin
      r_state     <= (CLR_ON_RST != 0) ? CLEAR : READY;
      r_clr_addr  <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_addr  <= w_clr_addr_nxt;
      r_init_done <= (r_state == READY);
    end
  end

  // Next-state and sweep write-request logic.
  always_comb begin
    // NOTE: every output of this block gets a default first. Then no path
    // leaves a value unassigned, and no latch is inferred.
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    o_clr_we       = 1'b0;
    case (r_state)
      CLEAR: begin
        o_clr_we = 1'b1;
        if (r_clr_addr == LAST_ADDR) w_state_nxt = READY;
        else                         w_clr_addr_nxt = r_clr_addr + ADDR_W'(1);
      end
      READY:   w_state_nxt = READY;
      default: w_state_nxt = READY;
    endcase
  end

  assign o_clr_addr  = r_clr_addr;
  assign o_init_done = r_init_done;

endmodule

// File: rtl/sram_dp_be.sv
// Simple dual-port SRAM with byte enables: one write port and one read port
// on a single clock.
// - Write-first read-during-write forwarding, resolved per byte.
// - Read-valid strobe on the read port.
// - Zero-fill sweep after reset. User accesses are accepted only once
//   init_done is high.
// - Out-of-range writes are dropped. Out-of-range reads return 0 with rvalid.
// Optional macro SRAM_OUT_REG_EN adds an output register stage (read latency
// 2). Forwarding is still resolved in the strobe cycle.
module sram_dp_be
  import sram_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 8192,
  parameter int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int BE_W       = DATA_W / 8,
  parameter int CLR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wsbn,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   wbe,
  input  logic              csbn,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              init_done
);

  if ((DATA_W % 8) != 0 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
    $error("sram_dp_be: DATA_W must be a multiple of 8 and at most MAX_DATA_W");
  end

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  // NOTE: the array has no reset. A reset term would stop it mapping onto an
  // SRAM macro. The clear sweep provides the zero contents instead.
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_init_done;

  sram_clr_ctrl #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .CLR_ON_RST (CLR_ON_RST)
  ) u_clr_ctrl (
    .clk         (clk),
    .rst         (rst),
    .o_clr_we    (w_clr_we),
    .o_clr_addr  (w_clr_addr),
    .o_init_done (w_init_done)
  );

  logic              w_wr_in_range;
  logic              w_rd_in_range;
  logic              w_usr_we;
  logic              w_usr_re;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [BE_W-1:0]   w_wbe;
  logic              w_fwd;
  logic [DATA_W-1:0] w_rd_word;

  assign w_wr_in_range = ({1'b0, waddr} < DEPTH_C);
  assign w_rd_in_range = ({1'b0, raddr} < DEPTH_C);
  assign w_usr_we      = w_init_done & ~wsbn & w_wr_in_range;
  assign w_usr_re      = w_init_done & ~csbn;

  // The clear sweep owns the write port until init_done rises.
  assign w_we    = w_clr_we | w_usr_we;
  assign w_waddr = w_clr_we ? w_clr_addr : waddr;
  assign w_wdata = w_clr_we ? '0 : wdata;
  assign w_wbe   = w_clr_we ? '1 : wbe;

  // A same-address write in the strobe cycle overrides the enabled bytes.
  assign w_fwd     = w_usr_we && (waddr == raddr);
  assign w_rd_word = !w_rd_in_range ? '0 :
                     w_fwd ? DATA_W'(be_merge(MAX_DATA_W'(r_mem[raddr]),
                                              MAX_DATA_W'(wdata),
                                              MAX_BE_W'(wbe)))
                           : r_mem[raddr];

  // Byte-masked array write.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (w_wbe[i]) r_mem[w_waddr][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;

`ifdef SRAM_OUT_REG_EN
  logic [DATA_W-1:0] r_rdata_s1;
  logic              r_rvalid_s1;

  // Strobe-cycle capture of the (forwarded) read word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata_s1  <= '0;
      r_rvalid_s1 <= 1'b0;
    end else begin
      r_rvalid_s1 <= w_usr_re;
      if (w_usr_re) r_rdata_s1 <= w_rd_word;
    end
  end

  // Output register stage. rdata holds while no read completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= r_rvalid_s1;
      if (r_rvalid_s1) r_rdata <= r_rdata_s1;
    end
  end
`else
  // Single-cycle read register. rdata holds while no read completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_usr_re;
      if (w_usr_re) r_rdata <= w_rd_word;
    end
  end
`endif

  assign rdata     = r_rdata;
  assign rvalid    = r_rvalid;
  assign init_done = w_init_done;

endmodule

// File: tb/tb_sram_dp_be.sv
// Directed bench for sram_dp_be. It uses two instances: DEPTH=16 (dut16) and
// DEPTH=12 (dut12, whose address space has out-of-range codes). Expected read
// latency follows SRAM_OUT_REG_EN.
module tb_sram_dp_be;

`ifdef SRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_wsbn, a_csbn, a_rvalid, a_init_done;
  logic [3:0]  a_waddr, a_raddr, a_wbe;
  logic [31:0] a_wdata, a_rdata;

  logic        b_wsbn, b_csbn, b_rvalid, b_init_done;
  logic [3:0]  b_waddr, b_raddr, b_wbe;
  logic [31:0] b_wdata, b_rdata;

  sram_dp_be #(.DATA_W(32), .DEPTH(16), .CLR_ON_RST(1)) u_dut16 (
    .clk(clk), .rst(rst), .wsbn(a_wsbn), .waddr(a_waddr), .wdata(a_wdata),
    .wbe(a_wbe), .csbn(a_csbn), .raddr(a_raddr), .rdata(a_rdata),
    .rvalid(a_rvalid), .init_done(a_init_done)
  );

  sram_dp_be #(.DATA_W(32), .DEPTH(12), .CLR_ON_RST(1)) u_dut12 (
    .clk(clk), .rst(rst), .wsbn(b_wsbn), .waddr(b_waddr), .wdata(b_wdata),
    .wbe(b_wbe), .csbn(b_csbn), .raddr(b_raddr), .rdata(b_rdata),
    .rvalid(b_rvalid), .init_done(b_init_done)
  );

  typedef struct {
    logic        sel;        // 0: dut16, 1: dut12
    logic        wsbn;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic        csbn;
    logic [3:0]  raddr;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[25];

  int n_pass  = 0;
  int n_total = 0;

  logic [3:0]  bb_addr[4];
  logic [31:0] bb_exp[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic sel, input logic wsbn, input logic [3:0] waddr,
                              input logic [31:0] wdata, input logic [3:0] wbe,
                              input logic csbn, input logic [3:0] raddr,
                              input logic exp_rvalid, input logic [31:0] exp_rdata);
    vec_t v;
    v.sel = sel; v.wsbn = wsbn; v.waddr = waddr; v.wdata = wdata; v.wbe = wbe;
    v.csbn = csbn; v.raddr = raddr; v.exp_rvalid = exp_rvalid; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic idle_all();
    a_wsbn = 1'b1; a_csbn = 1'b1; a_waddr = '0; a_raddr = '0; a_wdata = '0; a_wbe = '0;
    b_wsbn = 1'b1; b_csbn = 1'b1; b_waddr = '0; b_raddr = '0; b_wdata = '0; b_wbe = '0;
  endtask

  // Drive one vector for one cycle, then sample LAT edges later.
  task automatic apply_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    if (v.sel == 1'b0) begin
      a_wsbn = v.wsbn; a_waddr = v.waddr; a_wdata = v.wdata; a_wbe = v.wbe;
      a_csbn = v.csbn; a_raddr = v.raddr;
    end else begin
      b_wsbn = v.wsbn; b_waddr = v.waddr; b_wdata = v.wdata; b_wbe = v.wbe;
      b_csbn = v.csbn; b_raddr = v.raddr;
    end
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 1) idle_all();
    end
    check($sformatf("vec%0d rvalid", idx), 32'(v.sel ? b_rvalid : a_rvalid), 32'(v.exp_rvalid));
    check($sformatf("vec%0d rdata", idx), v.sel ? b_rdata : a_rdata, v.exp_rdata);
  endtask

  // Called at a negedge: one reset edge, released at the following negedge.
  task automatic pulse_rst();
    rst = 1'b1;
    idle_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Count edges after reset release until each init_done is seen (bounded).
  task automatic wait_init(output int n16, output int n12);
    n16 = 0;
    n12 = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (a_init_done && n16 == 0) n16 = c;
      if (b_init_done && n12 == 0) n12 = c;
      if (n16 != 0 && n12 != 0) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n16, n12, n;

    bb_addr[0] = 4'd11; bb_addr[1] = 4'd13; bb_addr[2] = 4'd11; bb_addr[3] = 4'd0;
    bb_exp[0] = 32'h0BADF00D; bb_exp[1] = 32'h0; bb_exp[2] = 32'h0BADF00D; bb_exp[3] = 32'h0;

    // dut16: writes, partial writes, forwarding, hold.
    vecs[0]  = mk(0, 0, 4'd3,  32'hDEADBEEF, 4'hF, 1, 4'd0,  0, 32'h0);
    vecs[1]  = mk(0, 0, 4'd3,  32'h0000AA00, 4'h2, 1, 4'd0,  0, 32'h0);
    vecs[2]  = mk(0, 1, 4'd0,  32'h0,        4'h0, 0, 4'd3,  1, 32'hDEADAAEF);
    vecs[3]  = mk(0, 0, 4'd5,  32'hAAAAAAAA, 4'hF, 1, 4'd0,  0, 32'hDEADAAEF);
    vecs[4]  = mk(0, 0, 4'd5,  32'h11223344, 4'hC, 0, 4'd5,  1, 32'h1122AAAA);
    vecs[5]  = mk(0, 1, 4'd0,  32'h0,        4'h0, 0, 4'd5,  1, 32'h1122AAAA);
    vecs[6]  = mk(0, 0, 4'd7,  32'hFFFFFFFF, 4'h0, 0, 4'd7,  1, 32'h0);
    vecs[7]  = mk(0, 1, 4'd0,  32'h0,        4'h0, 0, 4'd7,  1, 32'h0);
    vecs[8]  = mk(0, 0, 4'd4,  32'h55555555, 4'hF, 0, 4'd3,  1, 32'hDEADAAEF);
    vecs[9]  = mk(0, 0, 4'd15, 32'hCAFEF00D, 4'hF, 0, 4'd15, 1, 32'hCAFEF00D);
    vecs[10] = mk(0, 0, 4'd12, 32'h12345678, 4'hF, 1, 4'd0,  0, 32'hCAFEF00D);
    vecs[11] = mk(0, 1, 4'd0,  32'h0,        4'h0, 0, 4'd12, 1, 32'h12345678);
    vecs[12] = mk(0, 1, 4'd0,  32'h0,        4'h0, 1, 4'd0,  0, 32'h12345678);
    vecs[13] = mk(0, 0, 4'd0,  32'hA5A5A5A5, 4'h1, 0, 4'd0,  1, 32'h000000A5);
    vecs[14] = mk(0, 1, 4'd0,  32'h0,        4'h0, 0, 4'd4,  1, 32'h55555555);
    // dut12: boundary and out-of-range accesses.
    vecs[15] = mk(1, 0, 4'd11, 32'h0BADF00D, 4'hF, 1, 4'd0,  0, 32'h0);
    vecs[16] = mk(1, 1, 4'd0,  32'h0,        4'h0, 0, 4'd11, 1, 32'h0BADF00D);
    vecs[17] = mk(1, 0, 4'd13, 32'h77777777, 4'hF, 1, 4'd0,  0, 32'h0BADF00D);
    vecs[18] = mk(1, 1, 4'd0,  32'h0,        4'h0, 0, 4'd13, 1, 32'h0);
    vecs[19] = mk(1, 1, 4'd0,  32'h0,        4'h0, 0, 4'd1,  1, 32'h0);
    vecs[20] = mk(1, 0, 4'd13, 32'h66666666, 4'hF, 0, 4'd13, 1, 32'h0);
    vecs[21] = mk(1, 0, 4'd12, 32'h55555555, 4'hF, 0, 4'd0,  1, 32'h0);
    // dut16 after the interrupted and restarted sweep.
    vecs[22] = mk(0, 1, 4'd0,  32'h0,        4'h0, 0, 4'd1,  1, 32'h0);
    vecs[23] = mk(0, 1, 4'd0,  32'h0,        4'h0, 0, 4'd12, 1, 32'h0);
    vecs[24] = mk(0, 1, 4'd0,  32'h0,        4'h0, 0, 4'd3,  1, 32'h0);

    // Test 1: reset values, init latency, zero-filled contents.
    rst = 1'b1;
    idle_all();
    @(negedge clk);
    check("reset init_done", 32'(a_init_done), 32'h0);
    check("reset rvalid", 32'(a_rvalid), 32'h0);
    check("reset rdata", a_rdata, 32'h0);
    rst = 1'b0;
    wait_init(n16, n12);
    check("init latency depth16", 32'(n16), 32'd17);
    check("init latency depth12", 32'(n12), 32'd13);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a_csbn = 1'b0;
      a_raddr = 4'(i);
      for (int k = 1; k <= LAT; k++) begin
        @(negedge clk);
        if (k == 1) idle_all();
      end
      check($sformatf("clear rvalid a%0d", i), 32'(a_rvalid), 32'h1);
      check($sformatf("clear rdata a%0d", i), a_rdata, 32'h0);
    end

    // Tests 2/3 (and 6 under SRAM_OUT_REG_EN): table on dut16.
    for (int i = 0; i <= 14; i++) apply_vec(i);

    // Test 4: reset at clear address 7, write attempt during the sweep.
    @(negedge clk);
    pulse_rst();
    a_csbn = 1'b0; a_raddr = 4'd12;
    a_wsbn = 1'b0; a_waddr = 4'd2; a_wdata = 32'hFFFFFFFF; a_wbe = 4'hF;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("clear no rvalid %0d", c), 32'(a_rvalid), 32'h0);
    end
    pulse_rst();
    n = 0;
    for (int c = 1; c <= 100; c++) begin
      if (c == 10) begin
        a_wsbn = 1'b0; a_waddr = 4'd1; a_wdata = 32'hFFFFFFFF; a_wbe = 4'hF;
      end
      @(posedge clk);
      @(negedge clk);
      idle_all();
      if (a_init_done) begin
        n = c;
        break;
      end
    end
    check("restart init latency", 32'(n), 32'd17);
    for (int i = 22; i <= 24; i++) apply_vec(i);

    // Test 5: dut12 out-of-range behaviour and back-to-back reads.
    check("dut12 init_done", 32'(b_init_done), 32'h1);
    for (int i = 15; i <= 21; i++) apply_vec(i);
    for (int j = 0; j < 4 + LAT + 1; j++) begin
      @(negedge clk);
      if (j < LAT) begin
        check($sformatf("b2b early rvalid %0d", j), 32'(b_rvalid), 32'h0);
      end else if (j < 4 + LAT) begin
        check($sformatf("b2b rvalid %0d", j - LAT), 32'(b_rvalid), 32'h1);
        check($sformatf("b2b rdata %0d", j - LAT), b_rdata, bb_exp[j-LAT]);
      end else begin
        check("b2b trailing rvalid", 32'(b_rvalid), 32'h0);
      end
      if (j < 4) begin
        b_csbn = 1'b0;
        b_raddr = bb_addr[j];
      end else begin
        idle_all();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
